// File: rtl/traffic_lamp_monitor.sv
// Watches the phase code from a traffic controller and drives the lamps.
// Latches a fault on an illegal sequence, an early change or a stuck phase.
module traffic_lamp_monitor #(
  parameter int MIN_DWELL = 4,
  parameter int MAX_DWELL = 200,
  parameter int BLINK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light,
  input  logic       tick,
  input  logic       fault_clear,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] dwell_count
);

  localparam logic [7:0] MIN_C  = 8'(MIN_DWELL);
  localparam logic [7:0] MAX_C  = 8'(MAX_DWELL);
  localparam logic [7:0] BDIV_C = 8'(BLINK_DIV);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_EARLY   = 2'b10;
  localparam logic [1:0] CODE_STUCK   = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t     state, state_n;
  logic [1:0] cur, cur_n;
  logic [7:0] dwell_n;
  logic [1:0] code_n;
  logic       blink, blink_n;
  logic [7:0] bcnt, bcnt_n;
  logic       red_n, yellow_n, green_n;
  logic [7:0] dwell_inc;
  logic [7:0] bcnt_inc;
  logic [1:0] succ;

  assign dwell_inc = dwell_count + 8'd1;
  assign bcnt_inc  = bcnt + 8'd1;
  assign succ      = cur + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      dwell_count <= '0;
      blink       <= 1'b0;
      bcnt        <= '0;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
      lamp_red    <= 1'b0;
      lamp_yellow <= 1'b0;
      lamp_green  <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      dwell_count <= dwell_n;
      blink       <= blink_n;
      bcnt        <= bcnt_n;
      fault       <= (state_n == FAULT);
      fault_code  <= code_n;
      lamp_red    <= red_n;
      lamp_yellow <= yellow_n;
      lamp_green  <= green_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    dwell_n = dwell_count;
    code_n  = fault_code;
    blink_n = blink;
    bcnt_n  = bcnt;
    case (state)
      IDLE: begin
        cur_n   = light;
        dwell_n = '0;
        state_n = RUN;
      end
      RUN: begin
        if (light == cur) begin
          if (tick) begin
            dwell_n = dwell_inc;
            if (dwell_inc == MAX_C) begin
              state_n = FAULT;
              code_n  = CODE_STUCK;
            end
          end
        end else if (light != succ) begin
          // Sequence check wins over the dwell check
          state_n = FAULT;
          code_n  = CODE_ILLEGAL;
        end else if (dwell_count < MIN_C) begin
          state_n = FAULT;
          code_n  = CODE_EARLY;
        end else begin
          cur_n   = light;
          dwell_n = '0;
        end
        if (state_n == FAULT) begin
          blink_n = 1'b1;
          bcnt_n  = '0;
        end
      end
      FAULT: begin
        if (fault_clear) begin
          state_n = IDLE;
          code_n  = CODE_NONE;
          blink_n = 1'b0;
          bcnt_n  = '0;
        end else if (tick) begin
          if (bcnt_inc == BDIV_C) begin
            blink_n = ~blink;
            bcnt_n  = '0;
          end else begin
            bcnt_n  = bcnt_inc;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lamps decode the registered state, so they follow one cycle behind it
  always_comb begin
    red_n    = 1'b0;
    yellow_n = 1'b0;
    green_n  = 1'b0;
    case (state)
      RUN: begin
        red_n    = (cur == 2'b00);
        yellow_n = (cur == 2'b01);
        green_n  = (cur == 2'b10);
      end
      FAULT:   red_n = blink;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor with MIN_DWELL=4, MAX_DWELL=10, BLINK_DIV=2.
module tb_traffic_lamp_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] light;
  logic       tick;
  logic       fault_clear;
  logic       lamp_red, lamp_yellow, lamp_green, fault;
  logic [1:0] fault_code;
  logic [7:0] dwell_count;
  logic [2:0] lamps;

  int errors = 0;
  int checks = 0;

  assign lamps = {lamp_red, lamp_yellow, lamp_green};

  traffic_lamp_monitor #(.MIN_DWELL(4), .MAX_DWELL(10), .BLINK_DIV(2)) dut (
    .clk(clk), .reset(reset), .light(light), .tick(tick), .fault_clear(fault_clear),
    .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
    .fault(fault), .fault_code(fault_code), .dwell_count(dwell_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic restart(input logic [1:0] l);
    reset = 1'b1; tick = 1'b0; fault_clear = 1'b0;
    step();
    reset = 1'b0; light = l;
    step();
  endtask

  task test_reset();
    reset = 1'b1; light = 2'b01; tick = 1'b1; fault_clear = 1'b1;
    step(); step();
    checks++;
    if ({lamps, fault, fault_code, dwell_count} !== 14'd0) begin
      errors++;
      $display("FAIL reset_values: got lamps=%b fault=%b code=%b dwell=%0d, want all zero",
               lamps, fault, fault_code, dwell_count);
    end
    reset = 1'b0; tick = 1'b0; fault_clear = 1'b0;
    step();
    step();
    checks++;
    if (lamps !== 3'b010 || dwell_count !== 8'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL first_edge_capture: got lamps=%b dwell=%0d fault=%b, want 010 0 0",
               lamps, dwell_count, fault);
    end
  endtask

  task test_normal();
    restart(2'b00);
    checks++;
    if (lamps !== 3'b000) begin
      errors++;
      $display("FAIL idle_lamps: got %b want 000", lamps);
    end
    ticks(5);
    checks++;
    if (lamps !== 3'b100 || dwell_count !== 8'd5) begin
      errors++;
      $display("FAIL red_dwell: got lamps=%b dwell=%0d, want 100 5", lamps, dwell_count);
    end
    light = 2'b01;
    step();
    checks++;
    if (lamps !== 3'b100 || dwell_count !== 8'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL accept_edge: got lamps=%b dwell=%0d fault=%b, want 100 0 0",
               lamps, dwell_count, fault);
    end
    step();
    checks++;
    if (lamps !== 3'b010 || fault !== 1'b0) begin
      errors++;
      $display("FAIL yellow_lag: got lamps=%b fault=%b, want 010 0", lamps, fault);
    end
  endtask

  task test_early_change();
    logic [3:0] pat;
    pat = 4'b1001;
    ticks(2);
    light = 2'b10;
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || dwell_count !== 8'd2) begin
      errors++;
      $display("FAIL early_fault: got fault=%b code=%b dwell=%0d, want 1 10 2",
               fault, fault_code, dwell_count);
    end
    light = 2'b00;
    step();
    checks++;
    if (lamps !== 3'b100) begin
      errors++;
      $display("FAIL blink_entry: got lamps=%b want 100", lamps);
    end
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      light = 2'(i);
      step();
      checks++;
      if (lamp_red !== pat[3-i] || lamp_yellow !== 1'b0 || lamp_green !== 1'b0) begin
        errors++;
        $display("FAIL blink_%0d: got lamps=%b want red=%b", i, lamps, pat[3-i]);
      end
    end
    checks++;
    if (fault_code !== 2'b10 || dwell_count !== 8'd2) begin
      errors++;
      $display("FAIL fault_freeze: got code=%b dwell=%0d, want 10 2", fault_code, dwell_count);
    end
  endtask

  task test_clear();
    light = 2'b10; fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00) begin
      errors++;
      $display("FAIL clear: got fault=%b code=%b, want 0 00", fault, fault_code);
    end
    step();
    checks++;
    if (lamps !== 3'b000 || dwell_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_idle_lamps: got lamps=%b dwell=%0d, want 000 0", lamps, dwell_count);
    end
    step();
    checks++;
    if (lamps !== 3'b001 || fault !== 1'b0) begin
      errors++;
      $display("FAIL clear_green: got lamps=%b fault=%b, want 001 0", lamps, fault);
    end
    fault_clear = 1'b1;
    step(); step();
    fault_clear = 1'b0;
    checks++;
    if (lamps !== 3'b001 || fault !== 1'b0 || fault_code !== 2'b00) begin
      errors++;
      $display("FAIL clear_in_run: got lamps=%b fault=%b code=%b, want 001 0 00",
               lamps, fault, fault_code);
    end
  endtask

  task test_illegal();
    restart(2'b00);
    ticks(6);
    light = 2'b10;
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || dwell_count !== 8'd6) begin
      errors++;
      $display("FAIL illegal: got fault=%b code=%b dwell=%0d, want 1 01 6",
               fault, fault_code, dwell_count);
    end
    light = 2'b11; step();
    light = 2'b01; step();
    checks++;
    if (fault_code !== 2'b01 || fault !== 1'b1) begin
      errors++;
      $display("FAIL illegal_hold: got fault=%b code=%b, want 1 01", fault, fault_code);
    end
    restart(2'b00);
    light = 2'b11;
    step();
    checks++;
    if (fault_code !== 2'b01) begin
      errors++;
      $display("FAIL illegal_over_early: got code=%b want 01", fault_code);
    end
  endtask

  task test_stuck();
    restart(2'b00);
    ticks(9);
    checks++;
    if (fault !== 1'b0 || dwell_count !== 8'd9) begin
      errors++;
      $display("FAIL pre_stuck: got fault=%b dwell=%0d, want 0 9", fault, dwell_count);
    end
    ticks(1);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b11 || dwell_count !== 8'd10) begin
      errors++;
      $display("FAIL stuck: got fault=%b code=%b dwell=%0d, want 1 11 10",
               fault, fault_code, dwell_count);
    end
    ticks(3);
    checks++;
    if (dwell_count !== 8'd10 || fault_code !== 2'b11) begin
      errors++;
      $display("FAIL stuck_freeze: got code=%b dwell=%0d, want 11 10", fault_code, dwell_count);
    end
  endtask

  task test_min_boundary();
    restart(2'b00);
    ticks(4);
    light = 2'b01; tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (fault !== 1'b0 || dwell_count !== 8'd0) begin
      errors++;
      $display("FAIL accept_at_min_with_tick: got fault=%b dwell=%0d, want 0 0", fault, dwell_count);
    end
    ticks(3);
    light = 2'b10;
    step();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || dwell_count !== 8'd3) begin
      errors++;
      $display("FAIL early_below_min: got fault=%b code=%b dwell=%0d, want 1 10 3",
               fault, fault_code, dwell_count);
    end
  endtask

  task test_wrap_successor();
    restart(2'b11);
    ticks(4);
    step();
    checks++;
    if (lamps !== 3'b000 || dwell_count !== 8'd4) begin
      errors++;
      $display("FAIL off_phase: got lamps=%b dwell=%0d, want 000 4", lamps, dwell_count);
    end
    light = 2'b00;
    step(); step();
    checks++;
    if (lamps !== 3'b100 || fault !== 1'b0) begin
      errors++;
      $display("FAIL wrap_to_red: got lamps=%b fault=%b, want 100 0", lamps, fault);
    end
  endtask

  task test_reset_in_fault();
    restart(2'b00);
    light = 2'b10;
    step(); step();
    reset = 1'b1; fault_clear = 1'b0; tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if ({lamps, fault, fault_code, dwell_count} !== 14'd0) begin
      errors++;
      $display("FAIL reset_in_fault: got lamps=%b fault=%b code=%b dwell=%0d, want all zero",
               lamps, fault, fault_code, dwell_count);
    end
    reset = 1'b0; light = 2'b01;
    step(); step();
    checks++;
    if (lamps !== 3'b010 || fault !== 1'b0 || dwell_count !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_run: got lamps=%b fault=%b dwell=%0d, want 010 0 0",
               lamps, fault, dwell_count);
    end
  endtask

  initial begin
    reset = 1'b1; light = 2'b00; tick = 1'b0; fault_clear = 1'b0;
    test_reset();
    test_normal();
    test_early_change();
    test_clear();
    test_illegal();
    test_stuck();
    test_min_boundary();
    test_wrap_successor();
    test_reset_in_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameter MIN_DWELL, default 4, minimum ticks a phase SHALL be held before advancing.
REQ-002 Parameter MAX_DWELL, default 200, tick count at which a held phase SHALL be declared stuck (MIN_DWELL < MAX_DWELL <= 255).
REQ-003 Parameter BLINK_DIV, default 2, ticks per half-period of the fault blink.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 light  input  2  phase code from controller: 00 red, 01 yellow, 10 green, 11 off.
REQ-007 tick  input  1  one-cycle time-base pulse; dwell and blink count only on tick.
REQ-008 fault_clear  input  1  one-cycle request to leave FAULT.
REQ-009 lamp_red, lamp_yellow, lamp_green  output  1 each  registered lamp drives.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 fault_code  output  2  00 none, 01 illegal sequence, 10 early change, 11 stuck phase.
REQ-012 dwell_count  output  8  ticks spent in current accepted phase.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FAULT; internal registers cur[1:0] (accepted phase) and blink.
REQ-014 IDLE: next edge SHALL capture cur<=light, dwell_count<=0, go to RUN; lamps all 0 during IDLE.
REQ-015 RUN, light==cur: on tick dwell_count SHALL increment; if incremented value == MAX_DWELL, enter FAULT with code 11 on that edge.
REQ-016 RUN, light!=cur: legal successor SHALL be (cur+1) mod 4 only (00->01->10->11->00).
REQ-017 Non-successor code SHALL enter FAULT with code 01 (checked first, overrides early-change).
REQ-018 Legal successor with dwell_count < MIN_DWELL SHALL enter FAULT with code 10.
REQ-019 Legal successor with dwell_count >= MIN_DWELL SHALL set cur<=light, dwell_count<=0; a tick in the same cycle SHALL be ignored.
REQ-020 RUN lamp decode from cur, one-hot: 00 red, 01 yellow, 10 green, 11 all off; lamps change exactly one cycle after the accepting edge.
REQ-021 FAULT entry SHALL set fault=1, latch fault_code, freeze dwell_count and cur, set blink=1.
REQ-022 In FAULT, lamp_yellow=lamp_green=0, lamp_red=blink; blink SHALL toggle every BLINK_DIV ticks (counter cleared on FAULT entry).
REQ-023 In FAULT, light changes SHALL be ignored and fault_code SHALL not be overwritten.
REQ-024 fault_clear in FAULT SHALL transition to IDLE next edge, fault<=0, fault_code<=00; fault_clear in IDLE/RUN SHALL be ignored.
REQ-025 dwell_count SHALL never wrap; MAX_DWELL guarantees FAULT before 255.

Reset
REQ-026 reset SHALL take priority over every other input, regardless of state.
REQ-027 Reset values: state IDLE, cur=00, dwell_count=0, blink=0, fault=0, fault_code=00, all lamps 0.
REQ-028 Reset asserted mid-FAULT or mid-phase SHALL discard all history; first post-reset edge behaves per REQ-014.

Verification (MIN_DWELL=4, MAX_DWELL=10, BLINK_DIV=2)
REQ-029 Reset release, light=00, 5 ticks, light=01 -> lamp_red=1 then lamp_yellow=1 one cycle after change, dwell_count 5->0, fault=0.
REQ-030 cur=01 after 2 ticks, light=10 -> fault=1, fault_code=10, lamp_red blinks 1,1,0,0 pattern across ticks, dwell_count holds 2.
REQ-031 cur=00, light jumps to 10 after 6 ticks -> fault_code=01; subsequent light changes leave fault_code=01.
REQ-032 light held 00 for 10 ticks -> fault_code=11 on the 10th tick edge, dwell_count=10.
REQ-033 In FAULT pulse fault_clear with light=10 -> IDLE then RUN with cur=10, lamp_green=1, fault=0, fault_code=00; fault_clear in RUN has no effect.
REQ-034 Tick coincident with accepted change, and reset asserted during FAULT -> dwell_count=0 after change; post-reset all outputs at REQ-027 values.
